// File: rtl/window_3x3_pkg.sv
// rtl/window_3x3_pkg.sv - shared widths and types for the 3x3 window generator
package window_3x3_pkg;

    localparam int PIX_W   = 8;
    localparam int VLD_BIT = 8;
    localparam int TAP_W   = PIX_W + 1;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/window_3x3_line_buffer.sv
// rtl/window_3x3_line_buffer.sv - one image line of pixel storage
//
// Ports:
//   clk   - clock
//   we    - write enable; writes wdata to addr at the rising edge
//   addr  - shared read/write address
//   wdata - pixel to store
//   rdata - contents of addr before any write in this cycle (read-before-write)
module line_buffer
    import window_3x3_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pix_t                     wdata,
    output pix_t                     rdata
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Combinational read sees the value from before this cycle's write, so the
    // outgoing pixel can be handed to the next buffer in the same cycle.
    assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3.sv
// rtl/window_3x3.sv - 3x3 sliding window over a raster pixel stream
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   din       - {valid, pixel} in raster order, no backpressure
//   d_00-d_22 - window taps {window valid, pixel}; row 0 oldest, column 2 newest
//   frame_end - one-cycle pulse with the last window of a frame
module window_3x3
    import window_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAP_W-1:0] din,
    output logic [TAP_W-1:0] d_00,
    output logic [TAP_W-1:0] d_01,
    output logic [TAP_W-1:0] d_02,
    output logic [TAP_W-1:0] d_10,
    output logic [TAP_W-1:0] d_11,
    output logic [TAP_W-1:0] d_12,
    output logic [TAP_W-1:0] d_20,
    output logic [TAP_W-1:0] d_21,
    output logic [TAP_W-1:0] d_22,
    output logic             frame_end
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          pix_vld;
    pix_t          pix_in;
    pix_t          r1_q;
    pix_t          r2_q;
    logic          last_col;
    logic          last_row;
    logic          win_vld;
    pix_t          tap [3][3];

    assign pix_vld  = din[VLD_BIT];
    assign pix_in   = din[PIX_W-1:0];
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));

    // r1 holds the previous line; its old entry cascades into r2 so r2
    // always holds the line before that.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r1 (
        .clk   (clk),
        .we    (pix_vld & ~rst),
        .addr  (col),
        .wdata (pix_in),
        .rdata (r1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r2 (
        .clk   (clk),
        .we    (pix_vld & ~rst),
        .addr  (col),
        .wdata (r1_q),
        .rdata (r2_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_vld   <= 1'b0;
            frame_end <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    tap[i][j] <= '0;
                end
            end
        end else begin
            // Windows only from row>=2, col>=2: the three columns then all lie
            // on this line, and rows r-1/r-2 were written during this frame,
            // so neither wrap-arounds nor stale buffer contents can leak in.
            win_vld   <= pix_vld && (row >= RW'(2)) && (col >= CW'(2));
            frame_end <= pix_vld && last_col && last_row;
            if (pix_vld) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                for (int i = 0; i < 3; i++) begin
                    tap[i][0] <= tap[i][1];
                    tap[i][1] <= tap[i][2];
                end
                tap[0][2] <= r2_q;
                tap[1][2] <= r1_q;
                tap[2][2] <= pix_in;
            end
        end
    end

    assign d_00 = {win_vld, tap[0][0]};
    assign d_01 = {win_vld, tap[0][1]};
    assign d_02 = {win_vld, tap[0][2]};
    assign d_10 = {win_vld, tap[1][0]};
    assign d_11 = {win_vld, tap[1][1]};
    assign d_12 = {win_vld, tap[1][2]};
    assign d_20 = {win_vld, tap[2][0]};
    assign d_21 = {win_vld, tap[2][1]};
    assign d_22 = {win_vld, tap[2][2]};

endmodule

// File: tb/tb_window_3x3.sv
// tb/tb_window_3x3.sv - self-checking bench for window_3x3
module tb_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] din = '0;
    logic [8:0] d_00, d_01, d_02, d_10, d_11, d_12, d_20, d_21, d_22;
    logic       frame_end;

    window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .d_00      (d_00),
        .d_01      (d_01),
        .d_02      (d_02),
        .d_10      (d_10),
        .d_11      (d_11),
        .d_12      (d_12),
        .d_20      (d_20),
        .d_21      (d_21),
        .d_22      (d_22),
        .frame_end (frame_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [8:0]  v;
        logic [71:0] taps;
        logic        fe;
        int          cyc;
    } rec_t;

    typedef struct {
        int d00, d02, d11, d20, d22;
        bit fe;
    } tv_t;

    rec_t cap[$];
    rec_t exp_q[$];
    tv_t  tbl[4];
    logic [7:0] img[H][W];

    int applied     = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        logic [8:0] v;
        v = {d_00[8], d_01[8], d_02[8], d_10[8], d_11[8], d_12[8], d_20[8], d_21[8], d_22[8]};
        if (v != 9'h0 || frame_end)
            cap.push_back('{v, {d_00[7:0], d_01[7:0], d_02[7:0], d_10[7:0], d_11[7:0],
                                d_12[7:0], d_20[7:0], d_21[7:0], d_22[7:0]}, frame_end, cyc});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model(input int r, input int c);
        logic [71:0] e;
        e = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                e = {e[63:0], img[r-2+i][c-2+j]};
        return e;
    endfunction

    task automatic drive(input logic v, input logic [7:0] p);
        @(posedge clk);
        #1;
        din = {v, p};
    endtask

    task automatic send_frame(input int base, input int gap_lo, input int gap_hi, input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? 8'($urandom) : 8'(base + 16 * r + c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, img[r][c]);
                if (r >= 2 && c >= 2)
                    exp_q.push_back('{9'h1FF, model(r, c), (r == H-1 && c == W-1), cyc + 1});
                repeat ($urandom_range(gap_hi, gap_lo)) drive(1'b0, 8'($urandom));
            end
        end
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic check_table(input string tag, input int first, input int base);
        for (int k = 0; k < 4; k++) begin
            rec_t w;
            w = '{9'h0, 72'h0, 1'b0, 0};
            if (first + k < cap.size()) w = cap[first + k];
            chk($sformatf("%s_tbl%0d", tag, k),
                {w.taps[71:64], w.taps[55:48], w.taps[39:32], w.taps[23:16], w.taps[7:0], w.fe},
                {8'(base + tbl[k].d00), 8'(base + tbl[k].d02), 8'(base + tbl[k].d11),
                 8'(base + tbl[k].d20), 8'(base + tbl[k].d22), tbl[k].fe});
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, cap.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
            chk($sformatf("%s_vld%0d", tag, k), cap[k].v, exp_q[k].v);
            chk($sformatf("%s_taps%0d", tag, k), cap[k].taps, exp_q[k].taps);
            chk($sformatf("%s_fe%0d", tag, k), cap[k].fe, exp_q[k].fe);
            chk($sformatf("%s_lat%0d", tag, k), cap[k].cyc, exp_q[k].cyc);
        end
        cap.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {d_00, d_01, d_02, d_10, d_11, d_12, d_20, d_21, d_22, frame_end}, 128'h0);
    endtask

    initial begin
        tbl[0] = '{'h00, 'h02, 'h11, 'h20, 'h22, 1'b0};
        tbl[1] = '{'h01, 'h03, 'h12, 'h21, 'h23, 1'b0};
        tbl[2] = '{'h10, 'h12, 'h21, 'h30, 'h32, 1'b0};
        tbl[3] = '{'h11, 'h13, 'h22, 'h31, 'h33, 1'b1};

        // Reset with a valid pixel on din: it must be ignored.
        din = {1'b1, 8'hA5};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        din = '0;
        cap.delete();

        send_frame(0, 0, 0, 1'b0);
        flush();
        check_table("cont", 0, 0);
        check_all("cont");

        send_frame(0, 3, 3, 1'b0);
        flush();
        check_table("gap3", 0, 0);
        check_all("gap3");

        send_frame(0, 0, 0, 1'b0);
        send_frame('h80, 0, 0, 1'b0);
        flush();
        check_table("b2b_f0", 0, 0);
        check_table("b2b_f1", 4, 'h80);
        begin
            logic low_seen;
            low_seen = 1'b0;
            for (int k = 4; k < 8 && k < cap.size(); k++)
                for (int b = 0; b < 9; b++)
                    if (cap[k].taps[b*8 +: 8] < 8'h40) low_seen = 1'b1;
            chk("b2b_no_stale", low_seen, 1'b0);
        end
        check_all("b2b");

        // Abort after pixel (2,1) with a one-cycle reset.
        for (int p = 0; p < 2 * W + 2; p++)
            drive(1'b1, 8'(16 * (p / W) + (p % W)));
        @(posedge clk);
        #1;
        rst = 1'b1;
        din = {1'b1, 8'h55};
        @(posedge clk);
        #1;
        rst = 1'b0;
        din = '0;
        @(negedge clk);
        chk_zero("midframe_reset_state");
        send_frame(0, 0, 0, 1'b0);
        flush();
        check_table("abort", 0, 0);
        check_all("abort");

        send_frame(0, 0, 2, 1'b1);
        send_frame(0, 0, 2, 1'b1);
        flush();
        check_all("rand");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
